// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and pixel types shared by the scan-out path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [11:0]      color_t;

  // Horizontal line: active, front porch, sync, back porch (pixel clocks)
  localparam cnt_t H_ACTIVE   = 10'd640;
  localparam cnt_t H_FP       = 10'd16;
  localparam cnt_t H_SYNC     = 10'd96;
  localparam cnt_t H_BP       = 10'd48;
  localparam cnt_t H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam cnt_t H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam cnt_t H_TOTAL    = H_SYNC_END + H_BP;
  localparam cnt_t H_LAST     = H_TOTAL - cnt_t'(1);
  localparam cnt_t H_ACT_LAST = H_ACTIVE - cnt_t'(1);

  // Vertical frame: active, front porch, sync, back porch (lines)
  localparam cnt_t V_ACTIVE   = 10'd480;
  localparam cnt_t V_FP       = 10'd10;
  localparam cnt_t V_SYNC     = 10'd2;
  localparam cnt_t V_BP       = 10'd33;
  localparam cnt_t V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam cnt_t V_SYNC_END = V_SYNC_BEG + V_SYNC;
  localparam cnt_t V_TOTAL    = V_SYNC_END + V_BP;
  localparam cnt_t V_LAST     = V_TOTAL - cnt_t'(1);
  localparam cnt_t V_ACT_LAST = V_ACTIVE - cnt_t'(1);

  localparam color_t COLOR_BLACK = 12'h000;
  localparam color_t COLOR_WHITE = 12'hFFF;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v raster counters with raw sync, active and blanking decode.
// Latency: decode outputs are combinational from the counter flops (0 clk).
// Backpressure: none; advances every clk.
module vga_timing
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             pix_active,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             vblank_raw,
  output logic             frame_origin
);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Next raster position: h wraps every line, v steps only on the h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + cnt_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  // Counter state, cleared asynchronously so a restart always begins at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt        = h_cnt_q;
  assign v_cnt        = v_cnt_q;
  assign pix_active   = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
  assign hsync_raw    = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
  assign vsync_raw    = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
  assign vblank_raw   = (v_cnt_q >= V_ACTIVE);
  assign frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480 scan-out of an FB_W x FB_H frame buffer, each pixel a 4x4 screen block.
// Latency: rd_addr/rd_en 0 clk, hsync/vsync/de/color 2 clk, in_vblank/frame_start 1 clk after counters.
// Backpressure: none; RAM must return rd_data 1 clk after rd_en. VGA_SCANOUT_BORDER_EN adds a white border.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [14:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] color,
  output logic        de,
  output logic        in_vblank,
  output logic        frame_start
);

  localparam int ADDR_W = 15;
  localparam int COL_W  = $clog2(FB_W);
  localparam int ROW_W  = $clog2(FB_H);
  localparam logic [ADDR_W-1:0] FB_W_BITS = ADDR_W'(FB_W);

  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic              pix_active, hsync_raw, vsync_raw, vblank_raw, frame_origin;
  logic [ADDR_W-1:0] col_ext, row_ext, fb_addr;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, de_p1_q, de_p1_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  color_t            color_q, color_d;
  logic              in_vblank_q, in_vblank_d, frame_start_q, frame_start_d;
  logic              unused_cnt;
`ifdef VGA_SCANOUT_BORDER_EN
  logic              border_p1_q, border_p1_d;
`endif

  vga_timing u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .pix_active   (pix_active),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .vblank_raw   (vblank_raw),
    .frame_origin (frame_origin)
  );

  // Low counter bits select the sub-pixel within a 4x4 block and are not part of the address
  assign unused_cnt = ^{h_cnt, v_cnt};
  assign col_ext    = {{(ADDR_W-COL_W){1'b0}}, h_cnt[COL_W+1:2]};
  assign row_ext    = {{(ADDR_W-ROW_W){1'b0}}, v_cnt[ROW_W+1:2]};

  // row*FB_W + col as a constant shift-add over the set bits of FB_W
  always_comb begin
    fb_addr = col_ext;
    for (int i = 0; i < ADDR_W; i++) begin
      if (FB_W_BITS[i]) fb_addr = fb_addr + (row_ext << i);
    end
  end

  // Read strobe is held off during reset; address freezes on the last read during blanking
  assign rd_en   = pix_active & rst_n;
  assign rd_addr = rd_en ? fb_addr : addr_hold_q;

  // Two-stage delay so sync/de meet the RAM data, plus colour mux at the second stage
  always_comb begin
    addr_hold_d   = rd_en ? fb_addr : addr_hold_q;
    hs_p1_d       = hsync_raw;
    vs_p1_d       = vsync_raw;
    de_p1_d       = pix_active;
    hsync_d       = hs_p1_q;
    vsync_d       = vs_p1_q;
    de_d          = de_p1_q;
    color_d       = de_p1_q ? rd_data : COLOR_BLACK;
`ifdef VGA_SCANOUT_BORDER_EN
    border_p1_d   = (h_cnt == '0) || (h_cnt == H_ACT_LAST) ||
                    (v_cnt == '0) || (v_cnt == V_ACT_LAST);
    if (de_p1_q && border_p1_q) color_d = COLOR_WHITE;
`endif
    in_vblank_d   = vblank_raw;
    frame_start_d = frame_origin;
  end

  // Pipeline and status flops; sync lines idle high in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_q   <= '0;
      hs_p1_q       <= 1'b1;
      vs_p1_q       <= 1'b1;
      de_p1_q       <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      color_q       <= COLOR_BLACK;
      in_vblank_q   <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_SCANOUT_BORDER_EN
      border_p1_q   <= 1'b0;
`endif
    end else begin
      addr_hold_q   <= addr_hold_d;
      hs_p1_q       <= hs_p1_d;
      vs_p1_q       <= vs_p1_d;
      de_p1_q       <= de_p1_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      color_q       <= color_d;
      in_vblank_q   <= in_vblank_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_SCANOUT_BORDER_EN
      border_p1_q   <= border_p1_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign color       = color_q;
  assign in_vblank   = in_vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed table of raster points plus hand sequences for reset, blanking and sync counts.
// Latency: checks outputs 2 clk (1 clk for status) behind a raster position model.
// Backpressure: none; RAM model answers 1 clk after rd_en.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data = 12'h000;
  logic        hsync, vsync, de, in_vblank, frame_start;
  logic [11:0] color;

  vga_scanout #(.FB_W(160), .FB_H(120)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .color       (color),
    .de          (de),
    .in_vblank   (in_vblank),
    .frame_start (frame_start)
  );

  always #20 clk = ~clk;

`ifdef VGA_SCANOUT_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  int checks = 0;
  int passed = 0;
  bit lost   = 1'b0;

  // Frame-buffer RAM model: mode 0 returns the address, mode 1 a flat blue
  logic ram_mode = 1'b0;
  always @(posedge clk) if (rd_en) rd_data <= ram_mode ? 12'h00F : rd_addr[11:0];

  // Raster position model plus its 1- and 2-clk delayed copies
  int tb_h, tb_v, sh1, sv1, sh2, sv2;
  bit ok1, ok2;
  bit jump_req = 1'b0;
  logic [9:0] jump_fv = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_h <= 0; tb_v <= 0; sh1 <= 0; sv1 <= 0; sh2 <= 0; sv2 <= 0; ok1 <= 0; ok2 <= 0;
    end else begin
      sh1 <= tb_h; sv1 <= tb_v; sh2 <= sh1; sv2 <= sv1; ok1 <= 1'b1; ok2 <= ok1;
      if (tb_h == 799) begin
        tb_h <= 0;
        tb_v <= (tb_v == 524) ? 0 : tb_v + 1;
      end else begin
        tb_h <= tb_h + 1;
        if (jump_req) tb_v <= int'(jump_fv);
      end
    end
  end

  // Running statistics over the output stream
  bit mon_en = 1'b0;
  int cyc = 0, hs_low = 0, vs_low = 0, fs_cnt = 0, vb_run = 0, last_vb_run = -1;
  int blank_bad = 0, de_lag = -1, rd_rise_cyc = 0;
  bit vb_start_ok = 1'b0, p_rd = 1'b0, p_de = 1'b0, p_vb = 1'b0;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      cyc++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) fs_cnt++;
      if (!de && color != 12'h000) blank_bad++;
      if (rd_en && !p_rd) rd_rise_cyc = cyc;
      if (de && !p_de) de_lag = cyc - rd_rise_cyc;
      if (in_vblank && !p_vb) vb_start_ok = ok1 && sh1 == 0 && sv1 == 480;
      if (in_vblank) vb_run++;
      else begin
        if (p_vb) last_vb_run = vb_run;
        vb_run = 0;
      end
      p_rd = rd_en; p_de = de; p_vb = in_vblank;
    end
  end

  typedef struct {
    int         seg;
    int         h;
    int         v;
    logic       de;
    logic       hs;
    logic       vs;
    logic [11:0] col;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [11:0] bd(input logic [11:0] base);
    return BORDER ? 12'hFFF : base;
  endfunction

  task automatic add(input int s, input int h, input int v, input logic d, input logic hs,
                     input logic vs, input logic [11:0] c);
    vec_t e;
    e.seg = s; e.h = h; e.v = v; e.de = d; e.hs = hs; e.vs = vs; e.col = c;
    vecs.push_back(e);
  endtask

  // Wait until the output stage shows raster point (h,v)
  task automatic wait_out(input int h, input int v, output bit found);
    found = 1'b0;
    if (!lost) begin
      for (int n = 0; n < 60000; n++) begin
        @(negedge clk);
        if (ok2 && sh2 == h && sv2 == v) begin found = 1'b1; break; end
      end
    end
    if (!found) lost = 1'b1;
  endtask

  // Wait until the counters themselves sit at (h,v)
  task automatic wait_now(input int h, input int v, input string name);
    bit found;
    found = 1'b0;
    if (!lost) begin
      for (int n = 0; n < 60000; n++) begin
        @(negedge clk);
        if (rst_n && tb_h == h && tb_v == v) begin found = 1'b1; break; end
      end
    end
    if (!found) begin
      lost = 1'b1;
      chk({name, "_reach"}, 0, 1);
    end
  endtask

  task automatic run_seg(input int s);
    bit found;
    foreach (vecs[i]) begin
      if (vecs[i].seg == s) begin
        wait_out(vecs[i].h, vecs[i].v, found);
        if (!found) chk($sformatf("reach_%0d_%0d", vecs[i].h, vecs[i].v), 0, 1);
        else begin
          chk($sformatf("de@%0d,%0d", vecs[i].h, vecs[i].v), int'(de), int'(vecs[i].de));
          chk($sformatf("hsync@%0d,%0d", vecs[i].h, vecs[i].v), int'(hsync), int'(vecs[i].hs));
          chk($sformatf("vsync@%0d,%0d", vecs[i].h, vecs[i].v), int'(vsync), int'(vecs[i].vs));
          chk($sformatf("color@%0d,%0d", vecs[i].h, vecs[i].v), int'(color), int'(vecs[i].col));
        end
      end
    end
  endtask

  // Skip ahead by loading the vertical counter mid-line
  task automatic jump_v(input int h, input int v, input int to);
    wait_now(h, v, "jump");
    jump_fv  = 10'(to);
    jump_req = 1'b1;
    force dut.u_timing.v_cnt_q = jump_fv;
    @(negedge clk);
    release dut.u_timing.v_cnt_q;
    jump_req = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_color"}, int'(color), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_in_vblank"}, int'(in_vblank), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    // seg 0: first frame from reset, address-pattern RAM
    add(0,   0, 0, 1, 1, 1, bd(12'h000));
    add(0,   1, 0, 1, 1, 1, bd(12'h000));
    add(0,   8, 4, 1, 1, 1, 12'h0A2);
    add(0, 638, 4, 1, 1, 1, 12'h13F);
    add(0, 639, 4, 1, 1, 1, bd(12'h13F));
    add(0, 640, 4, 0, 1, 1, 12'h000);
    add(0, 655, 4, 0, 1, 1, 12'h000);
    add(0, 656, 4, 0, 0, 1, 12'h000);
    add(0, 751, 4, 0, 0, 1, 12'h000);
    add(0, 752, 4, 0, 1, 1, 12'h000);
    add(0,   3, 7, 1, 1, 1, 12'h0A0);
    add(0,  17, 9, 1, 1, 1, 12'h144);
    // seg 1: bottom of the frame and vertical blanking
    add(1,   4, 478, 1, 1, 1, 12'hA61);
    add(1,   0, 479, 1, 1, 1, bd(12'hA60));
    add(1,   4, 479, 1, 1, 1, bd(12'hA61));
    add(1, 639, 479, 1, 1, 1, bd(12'hAFF));
    add(1,   0, 480, 0, 1, 1, 12'h000);
    add(1,   0, 490, 0, 1, 0, 12'h000);
    add(1, 700, 491, 0, 0, 0, 12'h000);
    add(1,   0, 492, 0, 1, 1, 12'h000);
    // seg 2: next frame with flat-blue RAM
    add(2,   0, 0, 1, 1, 1, bd(12'h00F));
    add(2,   5, 1, 1, 1, 1, 12'h00F);
    add(2, 639, 2, 1, 1, 1, bd(12'h00F));
    add(2, 320, 3, 1, 1, 1, 12'h00F);
    add(2, 640, 3, 0, 1, 1, 12'h000);
    // seg 3: restart after a mid-line reset
    add(3,   0, 0, 1, 1, 1, bd(12'h00F));
    add(3,   2, 0, 1, 1, 1, bd(12'h00F));
    add(3,   8, 4, 1, 1, 1, 12'h00F);

    // Reset state while clocks run
    #130;
    chk_reset_outs("rst");

    // Release away from an edge; frame_start follows the first edge
    @(negedge clk);
    #5 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("frame_start_first", int'(frame_start), 1);
    run_seg(0);

    // Blanking holds the last read address
    wait_now(700, 10, "hold");
    chk("hold_rd_en", int'(rd_en), 0);
    chk("hold_rd_addr", int'(rd_addr), 479);

    // Line statistics over twelve full lines
    wait_now(0, 12, "stats0");
    #1;
    chk("hsync_low_12_lines", hs_low, 12 * 96);
    chk("vsync_low_early", vs_low, 0);
    chk("frame_start_once", fs_cnt, 1);
    chk("de_after_rd_en", de_lag, 2);
    chk("blank_black_0", blank_bad, 0);

    jump_v(100, 12, 477);
    run_seg(1);
    ram_mode = 1'b1;
    run_seg(2);

    // Frame statistics across the blanking interval and wrap
    wait_now(0, 4, "stats1");
    #1;
    chk("vsync_low_frame", vs_low, 1600);
    chk("frame_start_count", fs_cnt, 2);
    chk("vblank_run", last_vb_run, 36000);
    chk("vblank_start_pos", int'(vb_start_ok), 1);
    chk("blank_black_1", blank_bad, 0);

    // Asynchronous reset in the middle of a line
    jump_v(100, 4, 199);
    wait_now(300, 200, "midline");
    chk("mid_rd_en", int'(rd_en), 1);
    chk("mid_rd_addr", int'(rd_addr), 8075);
    chk("mid_de", int'(de), 1);
    mon_en = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    chk_reset_outs("async");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("async_hold");
    #5 rst_n = 1'b1;
    #1;
    chk("restart_rd_addr", int'(rd_addr), 0);
    @(negedge clk);
    chk("restart_frame_start", int'(frame_start), 1);
    run_seg(3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
